// File: rtl/led_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package led_pkg;

    typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;

    localparam int DIG_CODE_W = 5;
    localparam int DP_BIT     = 4;
    localparam int MAX_DIG    = 8;

    typedef logic [DIG_CODE_W-1:0] dig_code_t;

endpackage

// File: rtl/led_scan_timer.sv
// Digit slot timer: free-running 0..SCAN_DIV-1 counter with strobes marking
// the last blank cycle and the last cycle of the slot.
module led_scan_timer #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic blank_end,
    output logic slot_end
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt;

    assign blank_end = (cnt == CNT_W'(BLANK_CYC - 1));
    assign slot_end  = (cnt == CNT_W'(SCAN_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered digit codes,
// per-slot blanking and tear-free commit at the frame boundary.
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int NUM_DIG   = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr_en,
    input  logic [2:0]         i_wr_addr,
    input  logic [4:0]         i_wr_data,
    input  logic               i_commit,
    input  logic [NUM_DIG-1:0] i_dig_mask,
    output logic [4:0]         o_dig_ctrl,
    output logic [NUM_DIG-1:0] o_an,
    output logic               o_commit_pend,
    output logic               o_frame_done
);

    localparam int IDX_W = $clog2(MAX_DIG);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIG - 1);

    // Buffers are sized for the widest display; entries at or above NUM_DIG
    // are never written and stay at their reset value.
    dig_code_t          shadow [MAX_DIG];
    dig_code_t          active [MAX_DIG];
    scan_state_t        state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   next_idx;
    logic               blank_end;
    logic               slot_end;
    logic               wrap;
    logic [MAX_DIG-1:0] mask_ext;
    logic [MAX_DIG-1:0] sel_oh;
    logic [NUM_DIG-1:0] an_show;

    led_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    assign wrap     = slot_end && (idx == LAST_IDX);
    assign next_idx = wrap ? '0 : idx + 1'b1;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        mask_ext              = '0;
        mask_ext[NUM_DIG-1:0] = i_dig_mask;
        sel_oh                = '0;
        sel_oh[idx]           = mask_ext[idx];
        an_show               = ~sel_oh[NUM_DIG-1:0];
    end

    // NOTE: the digit buffers are reset explicitly because the display must
    // come up blank-coded; a large RAM would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow        <= '{default: '0};
            active        <= '{default: '0};
            state         <= ST_BLANK;
            idx           <= '0;
            o_dig_ctrl    <= '0;
            o_an          <= '1;
            o_commit_pend <= 1'b0;
            o_frame_done  <= 1'b0;
        end else begin
            if (i_wr_en && (int'(i_wr_addr) < NUM_DIG)) begin
                shadow[i_wr_addr] <= i_wr_data;
            end

            // The copy reads pre-edge shadow; a commit on the wrap cycle waits a frame.
            if (wrap) begin
                if (o_commit_pend) begin
                    active <= shadow;
                end
                o_commit_pend <= i_commit;
            end else if (i_commit) begin
                o_commit_pend <= 1'b1;
            end

            o_frame_done <= 1'b0;

            case (state)
                ST_BLANK: begin
                    o_an <= '1;
                    if (blank_end) begin
                        state <= ST_SHOW;
                        o_an  <= an_show;
                    end
                end
                ST_SHOW: begin
                    if (slot_end) begin
                        state        <= ST_BLANK;
                        idx          <= next_idx;
                        o_an         <= '1;
                        o_frame_done <= wrap;
                        o_dig_ctrl   <= (wrap && o_commit_pend) ? shadow[0]
                                                                : active[next_idx];
                    end else begin
                        o_an <= an_show;
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
Multiplexed seven-segment scan controller that sits directly upstream of the segment decoder. It holds a double-buffered 5-bit code per digit (bit 4 = decimal point, bits 3:0 = hex value). It time-multiplexes the digits, driving o_dig_ctrl into the decoder's 5-bit code input and the active-low digit anodes. A blanking gap between digits suppresses ghosting, and new display contents are committed tear-free at frame boundaries.

Parameters:
NUM_DIG, 8, number of digits scanned (2..8).
SCAN_DIV, 50000, clock cycles per digit slot (1 kHz per slot at 50 MHz).
BLANK_CYC, 16, cycles at the start of each slot with all anodes off; requires 1 <= BLANK_CYC < SCAN_DIV.

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
i_wr_en  in  1  write one shadow digit this cycle
i_wr_addr  in  3  digit index to write; index >= NUM_DIG is ignored
i_wr_data  in  5  {dp, hex[3:0]} code for that digit
i_commit  in  1  request copy of shadow buffer to active buffer at next frame boundary
i_dig_mask  in  NUM_DIG  1 = digit enabled; 0 = anode held off for its slot
o_dig_ctrl  out  5  code for the current digit, fed to the segment decoder
o_an  out  NUM_DIG  active-low one-hot anode select
o_commit_pend  out  1  commit requested, not yet applied
o_frame_done  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: shadow/active buffers all 5'h00, idx=0, cnt=0, state=BLANK, o_dig_ctrl=5'h00, o_an=all 1s, o_commit_pend=0, o_frame_done=0.
- Reset is honoured mid-slot and mid-commit: a pending commit is dropped, and the scan restarts at digit 0 in BLANK.
- Slot timer: cnt counts 0..SCAN_DIV-1 and wraps; slot length is exactly SCAN_DIV cycles.
- FSM, BLANK: o_an all 1s. At cnt==BLANK_CYC-1 -> SHOW.
- FSM, SHOW: o_an[idx]=0 if i_dig_mask[idx], else all 1s. i_dig_mask is sampled each cycle. At cnt==SCAN_DIV-1 -> BLANK, cnt=0, idx advances.
- Index advance: idx -> idx+1, wrapping NUM_DIG-1 -> 0.
- Frame boundary (wrap to 0): o_frame_done=1 for exactly that one cycle (the first BLANK cycle of digit 0).
- o_an and o_dig_ctrl are registered. o_dig_ctrl loads the new digit's code on the edge entering BLANK and is stable for the whole slot, so the code settles before the anode turns on.
- Shadow writes: i_wr_en writes i_wr_data into shadow[i_wr_addr] at the edge. The active buffer is never written directly.
- Commit request: i_commit sets the pending flag. Repeated commits while pending are idempotent.
- Commit application: on the wrap edge, if pending was set before that edge, active <= shadow and pending <= 0. On the same edge, o_dig_ctrl loads shadow[0] (the new data), not the old active[0].
- Simultaneous events: the copy uses pre-edge shadow. A write on the wrap cycle lands in shadow but misses that copy. i_commit asserted on the wrap cycle sets pending and is applied at the next wrap.
- o_commit_pend mirrors the pending flag (registered).
- Widths: cnt is $clog2(SCAN_DIV) bits; idx is 3 bits; comparisons are unsigned.

Decomposition:
- Shared package led_pkg: scan_state_t enum {ST_BLANK, ST_SHOW}, DIG_CODE_W=5, DP_BIT=4, MAX_DIG=8, digit code typedef dig_code_t (logic [4:0]).
- Sub-module led_scan_timer: slot counter plus blank/terminal strobes, parameterised by SCAN_DIV and BLANK_CYC.
- The buffers, FSM and commit logic stay in led_scan_ctrl.

Test Plan:
- Reset and scan timing (NUM_DIG=4, SCAN_DIV=8, BLANK_CYC=2, all masked on): release reset -> o_an = 4'b1111 for 2 cycles, then 4'b1110 for 6 cycles, then 4'b1111 for 2 cycles, then 4'b1101 for 6; o_frame_done pulses once every 32 cycles.
- Write and commit: write addr 0..3 with 5'h01, 5'h12, 5'h0A, 5'h1F, then pulse i_commit mid-frame -> o_dig_ctrl stays 5'h00 until the wrap edge, then reads 01,12,0A,1F in successive slots; o_commit_pend drops at the wrap.
- Commit on the wrap cycle: assert i_commit exactly when o_frame_done would fire -> data unchanged that frame, applied one frame (32 cycles) later.
- Mask: i_dig_mask=4'b1011 -> during digit 2's SHOW, o_an = 4'b1111 while o_dig_ctrl still shows shadow-committed code for digit 2.
- Out-of-range write: addr 5 with NUM_DIG=4 plus commit -> buffers unchanged.
- Reset mid-operation: pending commit plus rst_n low mid-SHOW -> all outputs at reset values immediately (async), buffers cleared, scan restarts at digit 0 BLANK.
